// File: rtl/hdmi_period_scheduler.sv
// Purpose: raster timing generator and TMDS period sequencer for an HDMI 1.4a transmitter.
//   Sequences control, video preamble/guard, active video, and data-island periods. It drives
//   the CTL preamble bits and gives each packet of the downstream assembler a start pulse and a
//   pixel index.
// Ports: clk_pixel/reset_n (async, active-low); packet_pending in; packet_start, packet_pixel,
//   cx, cy, mode, hsync, vsync, ctl_ch0..2 out. All outputs are registered and describe the same
//   (cx,cy). The assembler is paced by packet_start, which acts as the acknowledge for
//   packet_pending. There is no other backpressure: the raster always advances.
module hdmi_period_scheduler #(
    parameter int FRAME_WIDTH   = 800,
    parameter int FRAME_HEIGHT  = 525,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int HSYNC_START   = 656,
    parameter int HSYNC_END     = 752,
    parameter int VSYNC_START   = 490,
    parameter int VSYNC_END     = 492,
    parameter bit SYNC_ACTIVE   = 1'b0,
    parameter int MAX_PACKETS   = 18,
    parameter int BIT_WIDTH     = 10,
    parameter int BIT_HEIGHT    = 10
) (
    input  logic                  clk_pixel,
    input  logic                  reset_n,
    input  logic                  packet_pending,
    output logic                  packet_start,
    output logic [4:0]            packet_pixel,
    output logic [BIT_WIDTH-1:0]  cx,
    output logic [BIT_HEIGHT-1:0] cy,
    output logic [2:0]            mode,
    output logic                  hsync,
    output logic                  vsync,
    output logic [1:0]            ctl_ch0,
    output logic [1:0]            ctl_ch1,
    output logic [1:0]            ctl_ch2
);

    typedef enum logic [2:0] {
        CTRL, DI_PRE, DI_LGB, DI_BODY, DI_TGB, VID_PRE, VID_GB, VIDEO
    } state_t;

    localparam int PKT_W      = $clog2(MAX_PACKETS + 1);
    // Shortest island: preamble 8 + leading guard 2 + one packet 32 + trailing guard 2.
    localparam int ISLAND_MIN = SCREEN_WIDTH + 4 + 8 + 2 + 32 + 2;

    function automatic logic next_line_active(input int y);
        int ny;
        ny = (y == FRAME_HEIGHT - 1) ? 0 : y + 1;
        return ny < SCREEN_HEIGHT;
    endfunction

    // Islands must finish before the video preamble on lines that precede active video.
    function automatic int island_limit(input int y);
        return next_line_active(y) ? FRAME_WIDTH - 10 : FRAME_WIDTH;
    endfunction

    state_t                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [4:0]              pix_q, pix_d;
    logic [PKT_W-1:0]        pkt_q, pkt_d;
    logic [BIT_WIDTH-1:0]    cx_q, cx_d;
    logic [BIT_HEIGHT-1:0]   cy_q, cy_d;
    logic [2:0]              mode_q, mode_d;
    logic                    hsync_q, hsync_d, vsync_q, vsync_d;
    logic [1:0]              ctl1_q, ctl1_d, ctl2_q, ctl2_d;
    logic                    start_q, start_d;

    int   nx, ny, cxc, lim;
    logic nla_next, follow_raster;

    // Everything is computed for the *next* pixel and registered, so the state and all
    // outputs line up with the registered cx/cy.
    always_comb begin
        cx_d          = cx_q;
        cy_d          = cy_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        pix_d         = '0;
        pkt_d         = pkt_q;
        follow_raster = 1'b0;

        if (cx_q == BIT_WIDTH'(FRAME_WIDTH - 1)) begin
            cx_d = '0;
            cy_d = (cy_q == BIT_HEIGHT'(FRAME_HEIGHT - 1)) ? '0 : cy_q + 1'b1;
        end else begin
            cx_d = cx_q + 1'b1;
        end

        nx       = int'(cx_d);
        ny       = int'(cy_d);
        cxc      = int'(cx_q);
        lim      = island_limit(int'(cy_q));
        nla_next = next_line_active(ny);

        case (state_q)
            DI_PRE: begin
                if (cnt_q == 3'd7) begin
                    state_d = DI_LGB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DI_LGB: begin
                if (cnt_q == 3'd1) state_d = DI_BODY;
                else               cnt_d   = cnt_q + 1'b1;
            end
            DI_BODY: begin
                if (pix_q == 5'd31) begin
                    // Chain another packet only if one fits fully, with its trailing guard.
                    if (packet_pending && int'(pkt_q) < MAX_PACKETS && cxc + 1 + 32 + 2 <= lim) begin
                        pkt_d = pkt_q + 1'b1;
                    end else begin
                        state_d = DI_TGB;
                        cnt_d   = '0;
                    end
                end else begin
                    pix_d = pix_q + 1'b1;
                end
            end
            DI_TGB: begin
                if (cnt_q == 3'd1) follow_raster = 1'b1;
                else               cnt_d         = cnt_q + 1'b1;
            end
            default: follow_raster = 1'b1;
        endcase

        if (follow_raster) begin
            cnt_d = '0;
            pkt_d = '0;
            if (nx < SCREEN_WIDTH && ny < SCREEN_HEIGHT) begin
                state_d = VIDEO;
            end else if (nla_next && nx >= FRAME_WIDTH - 10 && nx <= FRAME_WIDTH - 3) begin
                state_d = VID_PRE;
            end else if (nla_next && nx >= FRAME_WIDTH - 2) begin
                state_d = VID_GB;
            end else if (state_q == CTRL && nx == SCREEN_WIDTH + 4 && packet_pending
                         && ISLAND_MIN <= lim) begin
                state_d = DI_PRE;
                pkt_d   = PKT_W'(1);
            end else begin
                state_d = CTRL;
            end
        end

        mode_d = 3'd0;
        case (state_d)
            VIDEO:          mode_d = 3'd1;
            VID_GB:         mode_d = 3'd2;
            DI_BODY:        mode_d = 3'd3;
            DI_LGB, DI_TGB: mode_d = 3'd4;
            default:        mode_d = 3'd0;
        endcase
        ctl1_d  = (state_d == VID_PRE || state_d == DI_PRE) ? 2'b01 : 2'b00;
        ctl2_d  = (state_d == DI_PRE) ? 2'b01 : 2'b00;
        start_d = (state_d == DI_BODY) && (pix_d == 5'd0);
        hsync_d = (nx >= HSYNC_START && nx < HSYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d = (ny >= VSYNC_START && ny < VSYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CTRL;
            cnt_q   <= '0;
            pix_q   <= '0;
            pkt_q   <= '0;
            cx_q    <= BIT_WIDTH'(SCREEN_WIDTH);
            cy_q    <= BIT_HEIGHT'(FRAME_HEIGHT - 1);
            mode_q  <= 3'd0;
            hsync_q <= ~SYNC_ACTIVE;
            vsync_q <= ~SYNC_ACTIVE;
            ctl1_q  <= 2'b00;
            ctl2_q  <= 2'b00;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pix_q   <= pix_d;
            pkt_q   <= pkt_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            mode_q  <= mode_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            ctl1_q  <= ctl1_d;
            ctl2_q  <= ctl2_d;
            start_q <= start_d;
        end
    end

    // pix_q is held at zero outside the island body, so it doubles as the packet index output.
    assign packet_pixel = pix_q;
    assign packet_start = start_q;
    assign cx           = cx_q;
    assign cy           = cy_q;
    assign mode         = mode_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign ctl_ch0      = {vsync_q, hsync_q};
    assign ctl_ch1      = ctl1_q;
    assign ctl_ch2      = ctl2_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
module tb_hdmi_period_scheduler;

    logic       clk = 1'b0;
    logic [2:0] rst_n;
    logic [2:0] pend;

    logic       ps [3];
    logic [4:0] pp [3];
    logic [9:0] cx [3];
    logic [9:0] cy [3];
    logic [2:0] md [3];
    logic       hs [3];
    logic       vs [3];
    logic [1:0] c0 [3];
    logic [1:0] c1 [3];
    logic [1:0] c2 [3];

    int n_chk  = 0;
    int n_fail = 0;

    // One recorded line: {cx, mode, ctl1, ctl2, start, pixel, hsync}
    logic [23:0] r_v [800];
    logic [2:0]  e_md [800];
    logic [1:0]  e_c1 [800];
    logic [1:0]  e_c2 [800];
    logic        e_ps [800];
    logic [4:0]  e_pp [800];
    logic        e_hs [800];

    always #5 clk = ~clk;

    // Instance 0: full 640x480 timing.
    hdmi_period_scheduler u_full (
        .clk_pixel(clk), .reset_n(rst_n[0]), .packet_pending(pend[0]),
        .packet_start(ps[0]), .packet_pixel(pp[0]), .cx(cx[0]), .cy(cy[0]), .mode(md[0]),
        .hsync(hs[0]), .vsync(vs[0]), .ctl_ch0(c0[0]), .ctl_ch1(c1[0]), .ctl_ch2(c2[0]));

    // Instance 1: short frame (20 lines, 12 active) so frame-level behaviour is reachable quickly.
    hdmi_period_scheduler #(.FRAME_HEIGHT(20), .SCREEN_HEIGHT(12), .VSYNC_START(14), .VSYNC_END(16)) u_short (
        .clk_pixel(clk), .reset_n(rst_n[1]), .packet_pending(pend[1]),
        .packet_start(ps[1]), .packet_pixel(pp[1]), .cx(cx[1]), .cy(cy[1]), .mode(md[1]),
        .hsync(hs[1]), .vsync(vs[1]), .ctl_ch0(c0[1]), .ctl_ch1(c1[1]), .ctl_ch2(c2[1]));

    // Instance 2: short frame, one packet per island.
    hdmi_period_scheduler #(.FRAME_HEIGHT(20), .SCREEN_HEIGHT(12), .VSYNC_START(14), .VSYNC_END(16),
                            .MAX_PACKETS(1)) u_max1 (
        .clk_pixel(clk), .reset_n(rst_n[2]), .packet_pending(pend[2]),
        .packet_start(ps[2]), .packet_pixel(pp[2]), .cx(cx[2]), .cy(cy[2]), .mode(md[2]),
        .hsync(hs[2]), .vsync(vs[2]), .ctl_ch0(c0[2]), .ctl_ch1(c1[2]), .ctl_ch2(c2[2]));

    task automatic wait_pos(input int k, input int x, input int y);
        int n;
        n = 0;
        while (!(int'(cx[k]) == x && int'(cy[k]) == y) && n < 40000) begin
            @(negedge clk);
            n++;
        end
        if (!(int'(cx[k]) == x && int'(cy[k]) == y)) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_pos inst%0d: at (%0d,%0d), required (%0d,%0d)", k, cx[k], cy[k], x, y);
        end
    endtask

    // Record one full line of instance k, with packet_pending driven to p from cx=0.
    // A nonzero stop_after drops packet_pending after that many packet_start pulses.
    task automatic record_line(input int k, input int y, input logic p, input int stop_after);
        int starts;
        starts = 0;
        wait_pos(k, 0, y);
        pend[k] = p;
        for (int i = 0; i < 800; i++) begin
            r_v[i] = {cx[k], md[k], c1[k], c2[k], ps[k], pp[k], hs[k]};
            if (ps[k]) begin
                starts++;
                if (starts == stop_after) pend[k] = 1'b0;
            end
            @(negedge clk);
        end
        pend[k] = 1'b0;
    endtask

    // Hand-derived raster expectations for an 800-pixel line.
    task automatic exp_base(input bit video, input bit nla);
        for (int i = 0; i < 800; i++) begin
            e_md[i] = (video && i < 640) ? 3'd1 : 3'd0;
            e_c1[i] = 2'b00;
            e_c2[i] = 2'b00;
            e_ps[i] = 1'b0;
            e_pp[i] = 5'd0;
            e_hs[i] = (i >= 656 && i < 752) ? 1'b0 : 1'b1;
            if (nla && i >= 790 && i <= 797) e_c1[i] = 2'b01;
            if (nla && i >= 798) e_md[i] = 3'd2;
        end
    endtask

    task automatic exp_island(input int n_pkts);
        int body_end;
        body_end = 654 + 32 * n_pkts;
        for (int i = 644; i <= 651; i++) begin
            e_md[i] = 3'd0; e_c1[i] = 2'b01; e_c2[i] = 2'b01;
        end
        e_md[652] = 3'd4; e_md[653] = 3'd4;
        for (int i = 654; i < body_end; i++) begin
            e_md[i] = 3'd3;
            e_pp[i] = 5'((i - 654) % 32);
            e_ps[i] = ((i - 654) % 32) == 0;
        end
        e_md[body_end] = 3'd4;
        e_md[body_end + 1] = 3'd4;
    endtask

    task automatic test_reset;
        rst_n = 3'b000;
        pend  = 3'b000;
        repeat (3) @(negedge clk);
        n_chk++; if (cx[0] !== 10'd640) begin n_fail++; $display("FAIL reset_cx: got %0d want 640", cx[0]); end
        n_chk++; if (cy[0] !== 10'd524) begin n_fail++; $display("FAIL reset_cy: got %0d want 524", cy[0]); end
        n_chk++; if (md[0] !== 3'd0) begin n_fail++; $display("FAIL reset_mode: got %0d want 0", md[0]); end
        n_chk++; if ({hs[0], vs[0]} !== 2'b11) begin n_fail++; $display("FAIL reset_sync: got %b want 11", {hs[0], vs[0]}); end
        n_chk++; if (ps[0] !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", ps[0]); end
        n_chk++; if (pp[0] !== 5'd0) begin n_fail++; $display("FAIL reset_pixel: got %0d want 0", pp[0]); end
        n_chk++; if ({c0[0], c1[0], c2[0]} !== 6'b110000) begin n_fail++; $display("FAIL reset_ctl: got %b want 110000", {c0[0], c1[0], c2[0]}); end
        n_chk++; if (cy[1] !== 10'd19) begin n_fail++; $display("FAIL reset_cy_short: got %0d want 19", cy[1]); end
        rst_n = 3'b111;
        @(posedge clk); #1;
        n_chk++; if ({cx[0], cy[0]} !== {10'd641, 10'd524}) begin n_fail++; $display("FAIL release_pos: got %0d,%0d want 641,524", cx[0], cy[0]); end
    endtask

    task automatic test_video_line;
        record_line(0, 0, 1'b0, 0);
        exp_base(1'b1, 1'b1);
        for (int i = 0; i < 800; i++) begin
            n_chk++;
            if (r_v[i] !== {10'(i), e_md[i], e_c1[i], e_c2[i], e_ps[i], e_pp[i], e_hs[i]}) begin
                n_fail++;
                $display("FAIL video_line cx=%0d: got %h want %h", i, r_v[i], {10'(i), e_md[i], e_c1[i], e_c2[i], e_ps[i], e_pp[i], e_hs[i]});
            end
        end
    endtask

    task automatic test_two_packets;
        record_line(0, 10, 1'b1, 2);
        exp_base(1'b1, 1'b1);
        exp_island(2);
        for (int i = 0; i < 800; i++) begin
            n_chk++;
            if (r_v[i] !== {10'(i), e_md[i], e_c1[i], e_c2[i], e_ps[i], e_pp[i], e_hs[i]}) begin
                n_fail++;
                $display("FAIL two_packets cx=%0d: got %h want %h", i, r_v[i], {10'(i), e_md[i], e_c1[i], e_c2[i], e_ps[i], e_pp[i], e_hs[i]});
            end
        end
    endtask

    task automatic test_back_to_back;
        record_line(0, 11, 1'b1, 0);
        exp_base(1'b1, 1'b1);
        exp_island(4);
        for (int i = 0; i < 800; i++) begin
            n_chk++;
            if (r_v[i] !== {10'(i), e_md[i], e_c1[i], e_c2[i], e_ps[i], e_pp[i], e_hs[i]}) begin
                n_fail++;
                $display("FAIL back_to_back cx=%0d: got %h want %h", i, r_v[i], {10'(i), e_md[i], e_c1[i], e_c2[i], e_ps[i], e_pp[i], e_hs[i]});
            end
        end
    endtask

    task automatic test_reset_mid_island;
        wait_pos(0, 0, 12);
        pend[0] = 1'b1;
        wait_pos(0, 700, 12);
        n_chk++; if ({md[0], pp[0]} !== {3'd3, 5'd14}) begin n_fail++; $display("FAIL mid_island_body: got mode %0d pix %0d want 3,14", md[0], pp[0]); end
        rst_n[0] = 1'b0;
        pend[0]  = 1'b0;
        #1;
        n_chk++; if ({cx[0], cy[0]} !== {10'd640, 10'd524}) begin n_fail++; $display("FAIL async_reset_pos: got %0d,%0d want 640,524", cx[0], cy[0]); end
        n_chk++; if ({md[0], ps[0], pp[0], c1[0], c2[0], hs[0]} !== 13'b000_0_00000_00_00_1) begin
            n_fail++; $display("FAIL async_reset_outputs: got %b want 0000000000001", {md[0], ps[0], pp[0], c1[0], c2[0], hs[0]});
        end
        @(negedge clk);
        rst_n[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_chk++;
            if ({cx[0], cy[0], md[0]} !== {10'(641 + i), 10'd524, 3'd0}) begin
                n_fail++;
                $display("FAIL resume_after_reset step %0d: got %0d,%0d mode %0d want %0d,524 mode 0", i, cx[0], cy[0], md[0], 641 + i);
            end
        end
    endtask

    task automatic test_max_packets;
        record_line(2, 3, 1'b1, 0);
        exp_base(1'b1, 1'b1);
        exp_island(1);
        for (int i = 0; i < 800; i++) begin
            n_chk++;
            if (r_v[i] !== {10'(i), e_md[i], e_c1[i], e_c2[i], e_ps[i], e_pp[i], e_hs[i]}) begin
                n_fail++;
                $display("FAIL max_packets cx=%0d: got %h want %h", i, r_v[i], {10'(i), e_md[i], e_c1[i], e_c2[i], e_ps[i], e_pp[i], e_hs[i]});
            end
        end
    endtask

    task automatic test_non_nla_line;
        record_line(1, 11, 1'b1, 0);
        exp_base(1'b1, 1'b0);
        exp_island(4);
        for (int i = 0; i < 800; i++) begin
            n_chk++;
            if (r_v[i] !== {10'(i), e_md[i], e_c1[i], e_c2[i], e_ps[i], e_pp[i], e_hs[i]}) begin
                n_fail++;
                $display("FAIL non_nla cx=%0d: got %h want %h", i, r_v[i], {10'(i), e_md[i], e_c1[i], e_c2[i], e_ps[i], e_pp[i], e_hs[i]});
            end
        end
    endtask

    task automatic test_vsync;
        logic want;
        for (int y = 12; y <= 17; y++) begin
            wait_pos(1, 0, y);
            want = (y == 14 || y == 15) ? 1'b0 : 1'b1;
            n_chk++;
            if ({vs[1], c0[1][1]} !== {want, want}) begin
                n_fail++;
                $display("FAIL vsync line %0d: got %b/%b want %b", y, vs[1], c0[1][1], want);
            end
        end
    endtask

    task automatic test_frame_wrap;
        record_line(1, 19, 1'b0, 0);
        exp_base(1'b0, 1'b1);
        for (int i = 0; i < 800; i++) begin
            n_chk++;
            if (r_v[i] !== {10'(i), e_md[i], e_c1[i], e_c2[i], e_ps[i], e_pp[i], e_hs[i]}) begin
                n_fail++;
                $display("FAIL last_line cx=%0d: got %h want %h", i, r_v[i], {10'(i), e_md[i], e_c1[i], e_c2[i], e_ps[i], e_pp[i], e_hs[i]});
            end
        end
        n_chk++;
        if ({cx[1], cy[1], md[1]} !== {10'd0, 10'd0, 3'd1}) begin
            n_fail++;
            $display("FAIL frame_wrap: got %0d,%0d mode %0d want 0,0 mode 1", cx[1], cy[1], md[1]);
        end
    endtask

    initial begin
        test_reset;
        test_video_line;
        test_two_packets;
        test_back_to_back;
        test_reset_mid_island;
        test_max_packets;
        test_non_nla_line;
        test_vsync;
        test_frame_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hdmi_period_scheduler.md
Name: hdmi_period_scheduler

Overview:
- Raster timing generator and TMDS period sequencer for the HDMI 1.4a transmitter.
- Sequences the per-pixel mode for all three TMDS channels: control, video preamble, video guard band, active video, data-island preamble, island guard bands and island body.
- Drives the CTL preamble bits and paces the downstream packet assembler through a start/pixel-index handshake.
- Sits between the clock/reset wrapper and the three TMDS channel encoders.

Parameters:
- FRAME_WIDTH, 800, total pixels per line
- FRAME_HEIGHT, 525, total lines per frame
- SCREEN_WIDTH, 640, active pixels per line
- SCREEN_HEIGHT, 480, active lines per frame
- HSYNC_START, 656, first cx with hsync asserted
- HSYNC_END, 752, first cx after hsync
- VSYNC_START, 490, first cy with vsync asserted
- VSYNC_END, 492, first cy after vsync
- SYNC_ACTIVE, 0, asserted level of hsync/vsync
- MAX_PACKETS, 18, max packets per data island
- BIT_WIDTH, 10, width of cx
- BIT_HEIGHT, 10, width of cy

Ports:
- clk_pixel  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- packet_pending  in  1  level; assembler has a packet ready
- packet_start  out  1  pulse on the first body pixel of each packet (acts as the ack)
- packet_pixel  out  5  pixel index 0..31 within the current packet; 0 outside the body
- cx  out  BIT_WIDTH  current x
- cy  out  BIT_HEIGHT  current y
- mode  out  3  0 control, 1 video, 2 video guard, 3 island body, 4 island guard
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- ctl_ch0  out  2  {vsync,hsync}
- ctl_ch1  out  2  {CTL1,CTL0}
- ctl_ch2  out  2  {CTL3,CTL2}

Behaviour:
- Interface: one clock, clk_pixel. reset_n is asynchronous and active-low.
- All outputs are registered and mutually consistent: every output describes the position (cx,cy) presented in the same cycle.
- Reset values: cx=SCREEN_WIDTH; cy=FRAME_HEIGHT-1; mode=0; ctl_ch1=ctl_ch2=00; hsync=vsync=!SYNC_ACTIVE; packet_start=0; packet_pixel=0; FSM in CTRL.
- Counters: cx increments and wraps FRAME_WIDTH-1→0. On that wrap cy increments and wraps FRAME_HEIGHT-1→0.
- Syncs: hsync=SYNC_ACTIVE iff HSYNC_START≤cx<HSYNC_END. vsync=SYNC_ACTIVE iff VSYNC_START≤cy<VSYNC_END. Both apply in every period.
- Video region: cx<SCREEN_WIDTH and cy<SCREEN_HEIGHT → mode=1.
- Next-line-active (NLA): the next line number (cy+1, or 0 after the last line) is < SCREEN_HEIGHT.
- On NLA lines:
  - cx in FRAME_WIDTH-10..FRAME_WIDTH-3: video preamble, mode=0, ctl_ch1=01, ctl_ch2=00.
  - cx in FRAME_WIDTH-2..FRAME_WIDTH-1: mode=2.
- Island limit L: FRAME_WIDTH-10 on NLA lines, else FRAME_WIDTH.
- FSM states: CTRL, DI_PRE(8), DI_LGB(2), DI_BODY, DI_TGB(2), VID_PRE(8), VID_GB(2), VIDEO.
- Island admission: only in CTRL at cx==SCREEN_WIDTH+4, any line, when packet_pending=1 and SCREEN_WIDTH+4+8+2+32+2 ≤ L. Otherwise no island on that line.
- DI_PRE: mode=0, ctl_ch1=01, ctl_ch2=01.
- DI_LGB and DI_TGB: mode=4, ctl_ch1=ctl_ch2=00.
- DI_BODY: mode=3. packet_pixel counts 0..31. packet_start=1 when packet_pixel=0.
- Packet boundary (packet_pixel=31): continue with a new packet iff all of the following hold; otherwise go to DI_TGB.
  - packet_pending=1 at that cycle;
  - packets sent so far < MAX_PACKETS;
  - cx+1+32+2 ≤ L.
- After DI_TGB: return to CTRL.
- Islands never overlap the video preamble; the admission and continuation checks guarantee this.
- Outside the preamble periods, ctl_ch1=ctl_ch2=00.
- packet_pending is only sampled at admission and at packet boundaries. Deassertion mid-packet is ignored and the current 32-pixel packet always completes.
- reset_n asserted mid-island or mid-video: asynchronous return to reset values. No trailing guard is emitted.

Test Plan:
- Reset: hold reset_n=0 → cx=640, cy=524, mode=0, hsync=vsync=1, packet_start=0. Release → cx=641 on the next edge.
- No packets, line cy=0 → mode=1 for cx 0..639; mode=0 with ctl_ch1=01, ctl_ch2=00 for cx 790..797; mode=2 at 798..799; hsync=0 for cx 656..751.
- packet_pending high for exactly 2 packets, line cy=10:
  - cx 644..651 mode=0, ctl_ch2=01;
  - cx 652..653 mode=4;
  - cx 654..717 mode=3, packet_start at 654 and 686;
  - cx 718..719 mode=4; cx 720 mode=0.
- packet_pending held high on cy=10 → exactly 4 packets (body 654..781), trailing guard 782..783. On cy=479 (non-NLA) → 4 packets, since a 5th would exceed 800. Rerun with MAX_PACKETS=1 → body 654..685 only.
- Frame wrap: cy=524, cx=799 → next cx=0, cy=0, mode=1. Preamble present on line 524; absent on line 479; vsync=0 on lines 490..491.
- Reset mid-island: pulse reset_n low at cx=700 during DI_BODY → outputs reset immediately, no mode=4 emitted. Operation then resumes normally from cx=641, cy=524.
